// File: rtl/gpio_bank_ctrl.sv
// Purpose: register-controlled GPIO bank with per-pin drive/direction, synchronised
//          inputs, sticky rise/fall edge flags and a maskable level interrupt.
// Latency: reads return one cycle after the request; pin-to-IN is SYNC_STAGES cycles.
//          Flags set one cycle after the synchronised edge. irq lags its cause by one cycle.
// Backpressure: none. The bus is always ready and accepts one access per cycle.
//
// Ports:
//   clk, nrst        clock and asynchronous active-low reset
//   en               bank enable; low forces pins to inputs and stops event capture
//   req_*            single-cycle register access strobe (write/addr/wdata)
//   rsp_valid/rdata  read response one cycle after a read strobe; rdata holds otherwise
//   irq              registered level interrupt
//   gpio_in/out/oeb  pad inputs, pad output values, pad output enables (active low)
module gpio_bank_ctrl #(
  parameter int NUM_PINS    = 34,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [NUM_PINS-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [NUM_PINS-1:0] rsp_rdata,
  output logic                irq,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb
);

  localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OEB     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RFLAG   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_FFLAG   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RISE_EN = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_FALL_EN = ADDR_W'(6);

  logic [NUM_PINS-1:0] out_q;
  logic [NUM_PINS-1:0] oeb_q;
  logic [NUM_PINS-1:0] rise_en_q;
  logic [NUM_PINS-1:0] fall_en_q;
  logic [NUM_PINS-1:0] rise_flag_q;
  logic [NUM_PINS-1:0] fall_flag_q;
  logic [NUM_PINS-1:0] prev_q;
  logic [NUM_PINS-1:0] sync_r [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_q;
  logic                en_q;

  logic                wr;
  logic                rd;
  logic                capture;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] rise_clr;
  logic [NUM_PINS-1:0] fall_clr;
  logic [NUM_PINS-1:0] rd_mux;
  logic                irq_next;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_comb begin
    wr       = req_valid & req_write;
    rd       = req_valid & ~req_write;
    rise     = sync_q & ~prev_q;
    fall     = ~sync_q & prev_q;
    // Capture needs en for two consecutive cycles so the first cycle after enabling
    // never reports an edge that really happened while the bank was off.
    capture  = en & en_q;
    rise_clr = (wr && req_addr == A_RFLAG) ? req_wdata : '0;
    fall_clr = (wr && req_addr == A_FFLAG) ? req_wdata : '0;
    irq_next = en & (|((rise_flag_q & rise_en_q) | (fall_flag_q & fall_en_q)));
  end

  always_comb begin
    rd_mux = '0;
    case (req_addr)
      A_OUT:     rd_mux = out_q;
      A_OEB:     rd_mux = oeb_q;
      A_IN:      rd_mux = sync_q;
      A_RFLAG:   rd_mux = rise_flag_q;
      A_FFLAG:   rd_mux = fall_flag_q;
      A_RISE_EN: rd_mux = rise_en_q;
      A_FALL_EN: rd_mux = fall_en_q;
      default:   rd_mux = '0;
    endcase
  end

  // Synchroniser and previous-sample register run regardless of en.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_q <= '0;
      en_q   <= 1'b0;
    end else begin
      sync_r[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_q <= sync_q;
      en_q   <= en;
    end
  end

  // Control registers; writes are accepted even while en is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr) begin
      case (req_addr)
        A_OUT:     out_q     <= req_wdata;
        A_OEB:     oeb_q     <= req_wdata;
        A_RISE_EN: rise_en_q <= req_wdata;
        A_FALL_EN: fall_en_q <= req_wdata;
        default:   ;
      endcase
    end
  end

  // Sticky flags: the set term is OR'ed after the clear so a same-edge event survives W1C.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rise_flag_q <= '0;
      fall_flag_q <= '0;
    end else begin
      rise_flag_q <= (rise_flag_q & ~rise_clr) | (rise & {NUM_PINS{capture}});
      fall_flag_q <= (fall_flag_q & ~fall_clr) | (fall & {NUM_PINS{capture}});
    end
  end

  // Read response and interrupt; rd_mux sees pre-update register values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      rsp_valid <= rd;
      if (rd) rsp_rdata <= rd_mux;
      irq <= irq_next;
    end
  end

  assign gpio_out = en ? out_q : '0;
  assign gpio_oeb = en ? oeb_q : '1;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
module tb_gpio_bank_ctrl;

  localparam int N  = 34;
  localparam int S  = 2;
  localparam int AW = 3;
  localparam logic [N-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [N-1:0]  req_wdata = '0;
  logic          rsp_valid;
  logic [N-1:0]  rsp_rdata;
  logic          irq;
  logic [N-1:0]  gpio_in = '0;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_oeb;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  gpio_bank_ctrl #(.NUM_PINS(N), .SYNC_STAGES(S), .ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq(irq),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[k] is the pad value sampled k+1 edges ago; the synchronised value is the
  // pad value from S edges back, and the previous sample is one edge older than that.
  logic [N-1:0] hist [0:S];
  logic [N-1:0] m_out, m_oeb, m_ren, m_fen, m_rflag, m_fflag, m_rdata;
  logic         m_rvalid, m_irq, m_en_prev;
  logic [N-1:0] m_s, m_p, m_w1r, m_w1f, m_rd;
  logic         m_cap;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k <= S; k++) hist[k] = '0;
      m_out = '0; m_oeb = '1; m_ren = '0; m_fen = '0;
      m_rflag = '0; m_fflag = '0; m_rdata = '0;
      m_rvalid = 1'b0; m_irq = 1'b0; m_en_prev = 1'b0;
    end else begin
      m_s   = hist[S-1];
      m_p   = hist[S];
      m_cap = en && m_en_prev;
      case (req_addr)
        3'd0: m_rd = m_out;
        3'd1: m_rd = m_oeb;
        3'd2: m_rd = m_s;
        3'd3: m_rd = m_rflag;
        3'd4: m_rd = m_fflag;
        3'd5: m_rd = m_ren;
        3'd6: m_rd = m_fen;
        default: m_rd = '0;
      endcase
      m_irq    = en && (((m_rflag & m_ren) | (m_fflag & m_fen)) != '0);
      m_rvalid = req_valid && !req_write;
      if (m_rvalid) m_rdata = m_rd;
      m_w1r = '0; m_w1f = '0;
      if (req_valid && req_write) begin
        case (req_addr)
          3'd0: m_out = req_wdata;
          3'd1: m_oeb = req_wdata;
          3'd3: m_w1r = req_wdata;
          3'd4: m_w1f = req_wdata;
          3'd5: m_ren = req_wdata;
          3'd6: m_fen = req_wdata;
          default: ;
        endcase
      end
      m_rflag = m_rflag & ~m_w1r;
      m_fflag = m_fflag & ~m_w1f;
      if (m_cap) begin
        m_rflag = m_rflag | (m_s & ~m_p);
        m_fflag = m_fflag | (~m_s & m_p);
      end
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0]   = gpio_in;
      m_en_prev = en;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic v, output logic [N-1:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    v = rsp_valid; d = rsp_rdata;
    req_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (S + 2) tick();
  endtask

  task automatic clear_flags();
    wr(3'd3, ALL1);
    wr(3'd4, ALL1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    gpio_in = N'({$urandom(), $urandom()});
    repeat (2) tick();
    tot_cnt++; if (gpio_oeb !== ALL1) $display("FAIL reset_oeb got %h want %h", gpio_oeb, ALL1); else pass_cnt++;
    tot_cnt++; if (gpio_out !== '0) $display("FAIL reset_out got %h want 0", gpio_out); else pass_cnt++;
    tot_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else pass_cnt++;
    tot_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    nrst = 1'b1;
    en   = 1'b0;
    wr(3'd1, '0);
    wr(3'd0, N'(34'h155));
    tick();
    tot_cnt++; if (gpio_oeb !== ALL1) $display("FAIL dis_oeb got %h want %h", gpio_oeb, ALL1); else pass_cnt++;
    tot_cnt++; if (gpio_out !== '0) $display("FAIL dis_out got %h want 0", gpio_out); else pass_cnt++;
    en = 1'b1;
    #1;
    tot_cnt++; if (gpio_out !== N'(34'h155)) $display("FAIL en_out got %h want 155", gpio_out); else pass_cnt++;
    tot_cnt++; if (gpio_oeb !== '0) $display("FAIL en_oeb got %h want 0", gpio_oeb); else pass_cnt++;
  endtask

  task automatic test_read_latency();
    logic [N-1:0] pins;
    pins = N'({$urandom(), $urandom()});
    gpio_in = pins;
    settle();
    wr(3'd5, N'(34'hF0));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
    tick();
    tot_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== N'(34'hF0)) $display("FAIL rd_rise_en got v=%b d=%h want v=1 d=f0", rsp_valid, rsp_rdata); else pass_cnt++;
    req_addr = 3'd7;
    tick();
    tot_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== '0) $display("FAIL rd_reserved got v=%b d=%h want v=1 d=0", rsp_valid, rsp_rdata); else pass_cnt++;
    req_addr = 3'd2;
    tick();
    tot_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== pins) $display("FAIL rd_in got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_rdata, pins); else pass_cnt++;
    req_valid = 1'b0;
    tick();
    tot_cnt++; if (rsp_valid !== 1'b0 || rsp_rdata !== pins) $display("FAIL rd_hold got v=%b d=%h want v=0 d=%h", rsp_valid, rsp_rdata, pins); else pass_cnt++;
    wr(3'd2, ALL1);
    gpio_in = ~pins;
    settle();
    wr(3'd2, '0);
    begin
      logic v; logic [N-1:0] d;
      rd(3'd2, v, d);
      tot_cnt++; if (d !== ~pins) $display("FAIL in_ro got %h want %h", d, ~pins); else pass_cnt++;
    end
  endtask

  task automatic test_sync_rise();
    logic v; logic [N-1:0] d;
    gpio_in = '0;
    wr(3'd5, '0);
    settle();
    clear_flags();
    gpio_in[3] = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      tot_cnt++; if (rsp_rdata[3] !== (k >= S + 1)) $display("FAIL sync_lat k=%0d got %b want %b", k, rsp_rdata[3], (k >= S + 1)); else pass_cnt++;
    end
    // Flag timing: a rise on bit 4 becomes visible one cycle after IN shows it.
    gpio_in[4] = 1'b1;
    req_addr = 3'd3;
    for (int k = 1; k <= S + 3; k++) begin
      tick();
      tot_cnt++; if (rsp_rdata !== ((k >= S + 2) ? N'(34'h18) : N'(34'h8))) $display("FAIL rflag_lat k=%0d got %h", k, rsp_rdata); else pass_cnt++;
    end
    req_valid = 1'b0;
    rd(3'd4, v, d);
    tot_cnt++; if (d !== '0) $display("FAIL fflag_quiet got %h want 0", d); else pass_cnt++;
    gpio_in[3] = 1'b0;
    settle();
    rd(3'd4, v, d);
    tot_cnt++; if (d !== N'(34'h8)) $display("FAIL fflag_set got %h want 8", d); else pass_cnt++;
  endtask

  task automatic test_w1c();
    logic v; logic [N-1:0] d;
    gpio_in = '0;
    settle();
    clear_flags();
    gpio_in = N'(34'h9);
    settle();
    rd(3'd3, v, d);
    tot_cnt++; if (d !== N'(34'h9)) $display("FAIL w1c_pre got %h want 9", d); else pass_cnt++;
    wr(3'd3, N'(34'h1));
    rd(3'd3, v, d);
    tot_cnt++; if (d !== N'(34'h8)) $display("FAIL w1c_clear got %h want 8", d); else pass_cnt++;
    gpio_in[0] = 1'b0; settle();
    gpio_in[0] = 1'b1; settle();
    gpio_in[0] = 1'b0; settle();
    rd(3'd3, v, d);
    tot_cnt++; if (d !== N'(34'h9)) $display("FAIL w1c_pre2 got %h want 9", d); else pass_cnt++;
    // Bit 0 rises so that its capture edge coincides with the W1C write.
    gpio_in[0] = 1'b1;
    repeat (S) tick();
    wr(3'd3, N'(34'h1));
    rd(3'd3, v, d);
    tot_cnt++; if (d !== N'(34'h9)) $display("FAIL w1c_collide got %h want 9", d); else pass_cnt++;
  endtask

  task automatic test_irq();
    logic v; logic [N-1:0] d;
    wr(3'd5, '0);
    wr(3'd6, '0);
    gpio_in = '0;
    settle();
    clear_flags();
    gpio_in[5] = 1'b1; settle();
    gpio_in[5] = 1'b0; settle();
    tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_masked got %b want 0", irq); else pass_cnt++;
    wr(3'd6, N'(34'h20));
    tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq); else pass_cnt++;
    tick();
    tot_cnt++; if (irq !== 1'b1) $display("FAIL irq_assert got %b want 1", irq); else pass_cnt++;
    wr(3'd4, N'(34'h20));
    tot_cnt++; if (irq !== 1'b1) $display("FAIL irq_clr_lag got %b want 1", irq); else pass_cnt++;
    tick();
    tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_clr got %b want 0", irq); else pass_cnt++;
    wr(3'd5, ALL1);
    tick();
    tot_cnt++; if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq); else pass_cnt++;
    en = 1'b0;
    tick();
    tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_dis got %b want 0", irq); else pass_cnt++;
    rd(3'd3, v, d);
    tot_cnt++; if (d[5] !== 1'b1) $display("FAIL flag_retain got %h want bit5 set", d); else pass_cnt++;
  endtask

  task automatic test_reentry();
    logic v; logic [N-1:0] d;
    en = 1'b0;
    gpio_in = ALL1 & ~(N'(1) << 7);
    settle();
    clear_flags();
    wr(3'd5, ALL1);
    // Bit 7's rise reaches the detector on the first enabled edge.
    gpio_in[7] = 1'b1;
    repeat (S) tick();
    en = 1'b1;
    repeat (3) tick();
    tot_cnt++; if (irq !== 1'b0) $display("FAIL reentry_irq got %b want 0", irq); else pass_cnt++;
    rd(3'd3, v, d);
    tot_cnt++; if (d !== '0) $display("FAIL reentry_rflag got %h want 0", d); else pass_cnt++;
    tot_cnt++; if (gpio_out !== N'(34'h155)) $display("FAIL reentry_out got %h want 155", gpio_out); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [N-1:0] eo, eb;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        nrst = 1'b0;
        #1;
        tot_cnt++; if (rsp_valid !== 1'b0 || irq !== 1'b0 || gpio_oeb !== ALL1) $display("FAIL rnd_rst c=%0d v=%b irq=%b oeb=%h", c, rsp_valid, irq, gpio_oeb); else pass_cnt++;
        nrst = 1'b1;
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) gpio_in = gpio_in ^ (N'(1) << $urandom_range(0, N - 1));
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = ($urandom_range(0, 1) == 0);
      req_addr  = AW'($urandom_range(0, 7));
      req_wdata = N'({$urandom(), $urandom()});
      if ($urandom_range(0, 1) == 0) req_wdata = req_wdata & N'({$urandom(), $urandom()});
      tick();
      eo = en ? m_out : '0;
      eb = en ? m_oeb : ALL1;
      tot_cnt++; if (gpio_out !== eo || gpio_oeb !== eb) $display("FAIL rnd_pins c=%0d out=%h/%h oeb=%h/%h", c, gpio_out, eo, gpio_oeb, eb); else pass_cnt++;
      tot_cnt++; if (irq !== m_irq) $display("FAIL rnd_irq c=%0d got %b want %b", c, irq, m_irq); else pass_cnt++;
      tot_cnt++; if (rsp_valid !== m_rvalid || rsp_rdata !== m_rdata) $display("FAIL rnd_rsp c=%0d got v=%b d=%h want v=%b d=%h", c, rsp_valid, rsp_rdata, m_rvalid, m_rdata); else pass_cnt++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_sync_rise();
    test_w1c();
    test_irq();
    test_reentry();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
- Parametrised GPIO bank controller that sits between a team project core and the breakout-board GPIO pins.
- Generalises the fixed 34-pin, always-output tie-off into a register-controlled bank with:
  - per-pin output value and direction
  - synchronised input sampling
  - rise/fall edge detection with sticky flags
  - a maskable interrupt
- The bank is gated by the chip enable.

Parameters:
- NUM_PINS, 34, number of GPIO pins; also the register/data width (1..34).
- SYNC_STAGES, 2, depth of the input synchroniser (2..4).
- ADDR_W, 3, register address width; fixed map uses 8 slots.

Ports:
- clk  input  1  system clock; all state on rising edge.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  bank enable; low disables pin drive and event capture.
- req_valid  input  1  register access strobe, one cycle per access.
- req_write  input  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  input  ADDR_W  register address.
- req_wdata  input  NUM_PINS  write data.
- rsp_valid  output  1  read data valid, one cycle.
- rsp_rdata  output  NUM_PINS  read data.
- irq  output  1  level interrupt.
- gpio_in  input  NUM_PINS  pad inputs.
- gpio_out  output  NUM_PINS  pad output values.
- gpio_oeb  output  NUM_PINS  pad output enables, active low.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk / nrst). nrst low immediately clears or loads all state:
  - OUT=0, OEB=all 1s (all pins inputs), RISE_EN=0, FALL_EN=0
  - RISE_FLAG=0, FALL_FLAG=0, synchroniser and previous-sample registers=0
  - rsp_valid=0, rsp_rdata=0, irq=0
- Register map (by req_addr):
  - 0 OUT, RW.
  - 1 OEB, RW.
  - 2 IN, RO; reads the synchronised pin value.
  - 3 RISE_FLAG, R/W1C.
  - 4 FALL_FLAG, R/W1C.
  - 5 RISE_EN, RW.
  - 6 FALL_EN, RW.
  - 7 reserved; reads 0, writes ignored.
  - Writes to address 2 are ignored.
- Bus:
  - Always ready; no back-pressure.
  - A write takes effect at the clock edge where req_valid=1 and req_write=1.
  - A read with req_valid=1 and req_write=0 gives rsp_valid=1 and rsp_rdata=value on the next cycle (1-cycle latency).
  - Read data is the register value before any same-edge update.
  - rsp_rdata holds its last value when rsp_valid=0.
  - Back-to-back reads every cycle are supported.
- Pin drive:
  - en=1: gpio_out=OUT, gpio_oeb=OEB, combinational from the registers.
  - en=0: gpio_out=0 and gpio_oeb=all 1s, regardless of the registers.
  - Register contents are retained while en=0, and writes are still accepted.
- Input path:
  - gpio_in passes through SYNC_STAGES flops; sync_q is the final stage.
  - The synchroniser runs regardless of en.
  - Pin-to-IN latency is SYNC_STAGES cycles.
- Edge detection:
  - prev <= sync_q every cycle.
  - rise = sync_q & ~prev; fall = ~sync_q & prev.
  - Detection is applied to every pin, regardless of OEB, so driven pins loop back.
- Flag capture:
  - Enabled only when en=1 and the previous cycle also had en=1.
  - So the first cycle after en rises captures no events, which avoids spurious edges.
- Flag update per bit:
  - RISE_FLAG <= (RISE_FLAG & ~w1c_mask) | (rise & capture).
  - w1c_mask = req_wdata when writing address 3, else 0.
  - FALL_FLAG follows the same rule for address 4.
  - A new event on the same cycle as its W1C wins: the flag stays 1.
  - Flags are independent of RISE_EN / FALL_EN.
- irq: registered, irq <= en & |((RISE_FLAG & RISE_EN) | (FALL_FLAG & FALL_EN)).
  - irq asserts 1 cycle after the relevant flag/enable combination becomes true.
  - irq is 0 while en=0.
- Widths: every register is NUM_PINS bits, and req_wdata bits map one-to-one to pins.
- Reset mid-operation:
  - Any pending read response is dropped, so rsp_valid=0.
  - Flags clear and pins revert to inputs immediately (asynchronous).

Test Plan:
- Reset and disable:
  - Stimulus: assert nrst=0 with en=1, random gpio_in.
  - Required: gpio_oeb=all 1s, gpio_out=0, irq=0, rsp_valid=0.
  - Then release reset, write OEB=0, OUT=0x155 with en=0.
  - Required: gpio_oeb stays all 1s; raising en gives gpio_out=0x155, gpio_oeb=0 the same cycle.
- Read latency:
  - Stimulus: write RISE_EN=0x0000_00F0, then read addresses 5, 7, 2 on consecutive cycles.
  - Required: rsp_valid=1 on each following cycle with data 0xF0, 0, and the synchronised gpio_in.
- Synchroniser and rise flag:
  - Stimulus: en=1 for ≥2 cycles, gpio_in[3] 0→1 at cycle T.
  - Required: IN[3]=1 from cycle T+SYNC_STAGES, and RISE_FLAG[3]=1 one cycle later.
  - FALL_FLAG stays 0 until gpio_in[3] returns to 0.
- W1C and collision:
  - Stimulus: with RISE_FLAG=0x9, write 0x1 to address 3.
  - Required: RISE_FLAG becomes 0x8.
  - Stimulus: repeat with a new rise on bit 0 on the same edge.
  - Required: RISE_FLAG[0] stays 1.
- Interrupt masking:
  - Stimulus: set FALL_FLAG[5] with FALL_EN=0.
  - Required: irq stays 0.
  - Stimulus: write FALL_EN=0x20.
  - Required: irq=1 one cycle later; W1C of bit 5 drops irq one cycle after the clear.
  - Stimulus: drop en.
  - Required: irq falls to 0.
- Enable re-entry:
  - Stimulus: hold gpio_in=all 1s with en=0, then raise en.
  - Required: no RISE_FLAG bits set, and irq stays 0 with RISE_EN=all 1s.
